// File: rtl/alu_pkg.sv
// Shared constants for the ALU result queue: sizes, sel codes and the
// layout of a stored entry {sel, cout, res}.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_DEPTH = 4;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  localparam int ENT_W    = ALU_WIDTH + 3;
  localparam int RES_LSB  = 0;
  localparam int COUT_BIT = ALU_WIDTH;
  localparam int SEL_LSB  = ALU_WIDTH + 1;

  function automatic int ent_w(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer/consumer handshake bundle of the ALU result queue.
// master = environment side, slave = the queue itself.
interface alu_result_queue_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_res;
  logic             in_cout;
  logic [1:0]       in_sel;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_cout;
  logic [1:0]       out_sel;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, in_res, in_cout, in_sel,
    output out_ready,
    input  in_ready,
    input  out_valid, out_res, out_cout,
    input  out_sel, out_zero, out_neg
  );

  modport slave (
    input  in_valid, in_res, in_cout, in_sel,
    input  out_ready,
    output in_ready,
    output out_valid, out_res, out_cout,
    output out_sel, out_zero, out_neg
  );

endinterface

// File: rtl/alu_rq_mem.sv
// Entry storage: one write port, one asynchronous read port.
// Contents are intentionally not reset.
module alu_rq_mem #(
  parameter int EW    = 19,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [EW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [EW-1:0]            o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_queue.sv
// Show-ahead FIFO for ALU results with zero/neg flags on the head
// and a sticky overflow flag for pushes attempted while full.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_queue_if.slave      q,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ent_w(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_head;

  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = q.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && q.out_ready;
  // A pop in the same cycle does not make room for a push.
  assign w_drop      = q.in_valid && !w_in_ready;
  assign w_wdata     = {q.in_sel, q.in_cout, q.in_res};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  alu_rq_mem #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_head)
  );

  assign q.in_ready  = w_in_ready;
  assign q.out_valid = w_out_valid;
  assign q.out_res   = w_head[WIDTH-1:0];
  assign q.out_cout  = w_head[WIDTH];
  assign q.out_sel   = w_head[WIDTH+2:WIDTH+1];
  assign q.out_zero  = (w_head[WIDTH-1:0] == '0);
  assign q.out_neg   = w_head[WIDTH-1];
  assign count       = r_count;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: vector table plus directed corner sequences,
// with a reference queue holding expected head entries.
module tb_alu_result_queue;
  import alu_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ovf_clr;
  logic [2:0] count;
  logic       ovf;

  alu_result_queue_if #(.WIDTH(W)) q ();

  alu_result_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .q       (q),
    .count   (count),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic [1:0]   sel;
  } ent_t;

  typedef struct {
    logic         v;
    logic [W-1:0] res;
    logic         c;
    logic [1:0]   s;
    logic         rdy;
    logic         clr;
    int           ecnt;
    logic         eovf;
  } vec_t;

  ent_t sb[$];
  logic m_ovf;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void check(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cycle(input logic v, input logic [W-1:0] res,
                       input logic c, input logic [1:0] s,
                       input logic rdy, input logic clr);
    int   sz;
    bit   full;
    ent_t e;
    q.in_valid  = v;
    q.in_res    = res;
    q.in_cout   = c;
    q.in_sel    = s;
    q.out_ready = rdy;
    ovf_clr     = clr;
    #1;
    sz = sb.size();
    check("in_ready", q.in_ready, sz != D);
    check("out_valid", q.out_valid, sz != 0);
    if (sz != 0) begin
      e = sb[0];
      check("out_res", q.out_res, e.res);
      check("out_cout", q.out_cout, e.cout);
      check("out_sel", q.out_sel, e.sel);
      check("out_zero", q.out_zero, e.res == '0);
      check("out_neg", q.out_neg, e.res[W-1]);
      if (rdy) void'(sb.pop_front());
    end
    full = (sz == D);
    if (v && !full) sb.push_back('{res, c, s});
    if (v && full) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("count", count, sb.size());
    check("ovf", ovf, m_ovf);
  endtask

  task automatic push(input logic [W-1:0] r);
    cycle(1'b1, r, r[0], r[2:1], 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
  endtask

  vec_t tbl[12];

  initial begin
    logic [W-1:0] rv;

    tbl[0]  = '{1'b1, 16'h00ab, 1'b0, SEL_ADD, 1'b0, 1'b0, 1, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, SEL_ADD, 1'b1, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b1, 16'hffa0, 1'b1, SEL_SUB, 1'b0, 1'b0, 1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0000, 1'b0, SEL_AND, 1'b0, 1'b0, 2, 1'b0};
    tbl[4]  = '{1'b1, 16'h8001, 1'b1, SEL_OR,  1'b0, 1'b0, 3, 1'b0};
    tbl[5]  = '{1'b1, 16'h1234, 1'b0, SEL_ADD, 1'b0, 1'b0, 4, 1'b0};
    tbl[6]  = '{1'b1, 16'hdead, 1'b1, SEL_OR,  1'b0, 1'b0, 4, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, SEL_ADD, 1'b0, 1'b1, 4, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, SEL_ADD, 1'b1, 1'b0, 3, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, SEL_ADD, 1'b1, 1'b0, 2, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, SEL_ADD, 1'b1, 1'b0, 1, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, SEL_ADD, 1'b1, 1'b0, 0, 1'b0};

    rst         = 1'b1;
    q.in_valid  = 1'b0;
    q.in_res    = '0;
    q.in_cout   = 1'b0;
    q.in_sel    = 2'b00;
    q.out_ready = 1'b0;
    ovf_clr     = 1'b0;
    m_ovf       = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", q.out_valid, 0);
    check("rst_in_ready", q.in_ready, 1);
    check("rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].res, tbl[i].c, tbl[i].s,
            tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_count", i), count, tbl[i].ecnt);
      check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].eovf);
    end

    // drop on a full queue even though a pop happens the same cycle
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    cycle(1'b1, 16'hbeef, 1'b1, SEL_SUB, 1'b1, 1'b0);
    check("drop_pop_count", count, 3);
    check("drop_pop_ovf", ovf, 1);
    cycle(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
    check("ovf_cleared", ovf, 0);
    push(16'h5555);
    cycle(1'b1, 16'h6666, 1'b0, SEL_AND, 1'b0, 1'b1);
    check("set_wins_ovf", ovf, 1);
    cycle(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
    repeat (4) pop1();

    // steady push+pop at count 2 across pointer wrap
    push(16'h0a0a); push(16'h0b0b);
    for (int i = 0; i < 10; i++) begin
      rv = 16'($urandom);
      cycle(1'b1, rv, rv[3], rv[5:4], 1'b1, 1'b0);
      check($sformatf("steady%0d_count", i), count, 2);
    end
    repeat (2) pop1();

    // empty-queue pops are ignored
    for (int i = 0; i < 5; i++) begin
      pop1();
      check($sformatf("empty%0d_count", i), count, 0);
      check($sformatf("empty%0d_ovf", i), ovf, 0);
    end

    // asynchronous reset mid-cycle with count 3 and ovf set
    push(16'h7001); push(16'h7002); push(16'h7003); push(16'h7004);
    cycle(1'b1, 16'h7005, 1'b0, 2'b00, 1'b1, 1'b0);
    q.in_valid  = 1'b0;
    q.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_out_valid", q.out_valid, 0);
    check("arst_in_ready", q.in_ready, 1);
    check("arst_ovf", ovf, 0);
    #1;
    rst = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    push(16'h8000);
    check("post_rst_count", count, 1);
    pop1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
